// File: rtl/pipe_trace_pkg.sv
// ============================================================================
// Module      : pipe_trace_pkg
// Description : Shared ASCII constants, hex helper, line length and FSM states
//               for the pipeline trace UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_trace_pkg;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } trace_state_e;

  // Hex digits plus one separator per word, plus the trailing LF
  function automatic int nchars(input int nstages, input int word_w);
    return nstages * (word_w / 4 + 1) + 1;
  endfunction

  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_tx.sv
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 byte serializer with valid/ready; accepts the next byte in
//               the final stop-bit cycle so characters run back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_tx #(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_e;

  localparam int                 c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIV - 1);

  ser_state_e         r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_baud, w_baud_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [7:0]         r_shift, w_shift_nxt;
  logic               r_tx, w_tx_nxt;
  logic               w_bit_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    ready_o     = 1'b0;
    w_bit_done  = (r_baud == c_last);

    case (r_state)
      S_IDLE: begin
        ready_o  = 1'b1;
        w_tx_nxt = 1'b1;
      end
      S_START: begin
        if (w_bit_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          ready_o     = 1'b1;
          w_baud_nxt  = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A handshake always launches a start bit, overriding the idle return
    if (valid_i && ready_o) begin
      w_state_nxt = S_START;
      w_baud_nxt  = '0;
      w_shift_nxt = data_i;
      w_tx_nxt    = 1'b0;
    end
  end

  assign tx_o = r_tx;

endmodule

`default_nettype wire

// File: rtl/pipe_trace_uart_tx.sv
// ============================================================================
// Module      : pipe_trace_uart_tx
// Description : Latches all pipeline stage words on a snapshot strobe and sends
//               them as one uppercase-hex ASCII line over an 8N1 UART pin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_trace_uart_tx
  import pipe_trace_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int BAUD    = 115_200,
  parameter int NSTAGES = 5,
  parameter int WORD_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      snap_i,
  input  logic [NSTAGES*WORD_W-1:0] instr_i,
  output logic                      busy_o,
  output logic [7:0]                drop_cnt_o,
  output logic                      uart_tx_o
);

  localparam int c_div    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int c_digits = WORD_W / 4;
  localparam int c_group  = c_digits + 1;
  localparam int c_nchars = nchars(NSTAGES, WORD_W);
  localparam int c_idx_w  = $clog2(c_nchars);

  trace_state_e              r_state, w_state_nxt;
  logic [c_idx_w-1:0]        r_idx, w_idx_nxt;
  logic [NSTAGES*WORD_W-1:0] r_capture, w_src;
  logic                      r_busy;
  logic [7:0]                r_drop;
  logic                      w_capture;
  logic                      w_valid;
  logic                      w_ser_ready;
  logic [31:0]               w_idx32, w_stage, w_pos;
  logic [WORD_W-1:0]         w_word;
  logic [3:0]                w_nibble;
  logic [7:0]                w_char;

  // In IDLE the first character comes straight off the live bus so its start
  // bit can begin in the cycle right after the accept.
  always_comb begin
    w_src    = (r_state == ST_IDLE) ? instr_i : r_capture;
    w_idx32  = 32'(r_idx);
    w_stage  = w_idx32 / c_group;
    w_pos    = w_idx32 % c_group;
    w_word   = '0;
    w_nibble = '0;
    for (int s = 0; s < NSTAGES; s++) begin
      if (w_stage == 32'(s)) w_word = w_src[s*WORD_W +: WORD_W];
    end
    for (int n = 0; n < c_digits; n++) begin
      if (w_pos == 32'(c_digits - 1 - n)) w_nibble = w_word[n*4 +: 4];
    end
    if (w_idx32 == 32'(c_nchars - 1))       w_char = ASCII_LF;
    else if (w_pos < 32'(c_digits))         w_char = hex2ascii(w_nibble);
    else if (w_stage == 32'(NSTAGES - 1))   w_char = ASCII_CR;
    else                                    w_char = ASCII_SP;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_valid = snap_i;
        if (snap_i && w_ser_ready) begin
          w_capture   = 1'b1;
          w_idx_nxt   = c_idx_w'(1);
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_valid = 1'b1;
        if (w_ser_ready) begin
          if (r_idx == c_idx_w'(c_nchars - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_ser_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_capture <= '0;
      r_busy    <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_capture) r_capture <= instr_i;
      if (snap_i && r_busy && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  uart_byte_tx #(
    .DIV (c_div)
  ) u_ser (
    .clk     (clk),
    .reset   (reset),
    .valid_i (w_valid),
    .data_i  (w_char),
    .ready_o (w_ser_ready),
    .tx_o    (uart_tx_o)
  );

  assign busy_o     = r_busy;
  assign drop_cnt_o = r_drop;

endmodule

`default_nettype wire
